// File: rtl/addsub_pkg.sv
// Shared definitions for the ALU add/sub datapath: op-mode encoding,
// saturation constants and configuration legality checks.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SADD = 2'd2,
    OP_SSUB = 2'd3
  } op_mode_e;

  localparam int MAX_W = 64;

  function automatic logic op_is_sub(input op_mode_e op);
    return op[0];
  endfunction

  function automatic logic op_is_sat(input op_mode_e op);
    return op[1];
  endfunction

  // Largest positive two's-complement value of width w: 0111...1
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < w - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Most negative two's-complement value of width w: 1000...0
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

  function automatic bit cfg_ok(input int w, input int blk, input int st);
    return (blk > 0) && (w > 0) && (w <= MAX_W) && ((w % blk) == 0) &&
           (st >= 1) && (st <= w / blk) && (((w / blk) % st) == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// BLOCK-bit combinational carry-lookahead adder cell with group
// propagate/generate outputs for the next lookahead level.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             p,
  output logic             g
);

  logic [BLOCK-1:0] pb;
  logic [BLOCK-1:0] gb;
  logic [BLOCK:0]   c;
  logic             gacc;

  assign pb = a ^ b;
  assign gb = a & b;

  // Written as a recurrence; synthesis flattens it into two-level lookahead.
  always_comb begin
    c    = '0;
    gacc = 1'b0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = gb[i] | (pb[i] & c[i]);
      gacc   = gb[i] | (pb[i] & gacc);
    end
  end

  assign s    = pb ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign p    = &pb;
  assign g    = gacc;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor with optional signed saturation and N/Z/V/C flags.
// Each stage resolves G blocks; upper operands ride forward, finished low bits accumulate.
module pipelined_cla_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int G    = NBLK / STAGES;
  localparam int SW   = G * BLOCK;
  localparam int L    = STAGES - 1;

  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
    $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and STAGES must divide WIDTH/BLOCK");
  end

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-1:LO] in_a;
    logic [WIDTH-1:LO] in_b;
    logic              in_c;
    logic              in_sat;
    logic              in_vld;
    logic [HI-1:0]     res;
    logic [G:0]        bc;
    logic [G-1:0]      bp;
    logic [G-1:0]      bg;
    logic [G-1:0]      bco;
    logic              unused_bco;

    assign unused_bco = ^bco;

    if (k == 0) begin : src
      assign in_a   = a;
      assign in_b   = b ^ {WIDTH{sub}};
      assign in_c   = sub;
      assign in_sat = sat;
      assign in_vld = in_valid;
    end else begin : src
      assign in_a          = stg[k-1].pr.q_a;
      assign in_b          = stg[k-1].pr.q_b;
      assign in_c          = stg[k-1].pr.q_c;
      assign in_sat        = stg[k-1].pr.q_sat;
      assign in_vld        = stg[k-1].pr.q_vld;
      assign res[LO-1:0]   = stg[k-1].pr.q_s;
    end

    assign bc[0] = in_c;

    // Second lookahead level: block carries come from group P/G.
    for (genvar j = 0; j < G; j++) begin : blk
      cla_block #(.BLOCK(BLOCK)) u_cla (
        .a    (in_a[LO + j*BLOCK +: BLOCK]),
        .b    (in_b[LO + j*BLOCK +: BLOCK]),
        .cin  (bc[j]),
        .s    (res[LO + j*BLOCK +: BLOCK]),
        .cout (bco[j]),
        .p    (bp[j]),
        .g    (bg[j])
      );
      assign bc[j+1] = bg[j] | (bp[j] & bc[j]);
    end

    if (k < L) begin : pr
      logic [WIDTH-1:HI] q_a;
      logic [WIDTH-1:HI] q_b;
      logic [HI-1:0]     q_s;
      logic              q_c;
      logic              q_sat;
      logic              q_vld;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_a   <= '0;
          q_b   <= '0;
          q_s   <= '0;
          q_c   <= 1'b0;
          q_sat <= 1'b0;
          q_vld <= 1'b0;
        end else if (adv) begin
          q_vld <= in_vld;
          if (in_vld) begin
            q_a   <= in_a[WIDTH-1:HI];
            q_b   <= in_b[WIDTH-1:HI];
            q_s   <= res;
            q_c   <= bc[G];
            q_sat <= in_sat;
          end
        end
      end
    end
  end

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] fin;
  logic             raw_co;
  logic             a_msb;
  logic             b_msb;
  logic             c_msb;
  logic             raw_ovf;
  logic             last_sat;
  logic             last_vld;

  assign raw      = stg[L].res;
  assign raw_co   = stg[L].bc[G];
  assign a_msb    = stg[L].in_a[WIDTH-1];
  assign b_msb    = stg[L].in_b[WIDTH-1];
  assign last_sat = stg[L].in_sat;
  assign last_vld = stg[L].in_vld;

  // Carry into the MSB recovered from its sum bit and effective operands.
  assign c_msb   = raw[WIDTH-1] ^ a_msb ^ b_msb;
  assign raw_ovf = c_msb ^ raw_co;
  assign fin     = (last_sat && raw_ovf) ? (a_msb ? SAT_MIN : SAT_MAX) : raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (adv) begin
      out_valid <= last_vld;
      if (last_vld) begin
        sum  <= fin;
        cout <= raw_co;
        ovf  <= raw_ovf;
        zero <= (fin == '0);
        neg  <= fin[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench: directed vectors with hand-computed results, decoupled monitor.
module tb_pipelined_cla_addsub;
  import addsub_pkg::*;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout, ovf, zero, neg;

  int n_vec = 0;
  int n_bad = 0;
  int n_checks = 0;

  res_t exp_q[$];

  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input op_mode_e op, input logic [15:0] va, input logic [15:0] vb,
                      input logic [15:0] es, input logic ec, input logic ev,
                      input logic ez, input logic en, input bit push);
    int guard;
    res_t r;
    guard = 0;
    @(negedge clk);
    a        = va;
    b        = vb;
    sub      = (op == OP_SUB) || (op == OP_SSUB);
    sat      = (op == OP_SADD) || (op == OP_SSUB);
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_bad++;
      $display("FAIL accept_timeout: in_ready stuck low, got 0, expected 1");
    end
    r = '{s: es, c: ec, v: ev, z: ez, n: en};
    if (push) exp_q.push_back(r);
    n_vec++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops on every handshake, checks hold behaviour across stalls.
  bit   stalled = 1'b0;
  res_t held;
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_sum", sum, held.s);
        check("stall_hold_flags", {cout, ovf, zero, neg}, {held.c, held.v, held.z, held.n});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got sum %h, expected no result", sum);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          check("ovf", ovf, e.v);
          check("zero", zero, e.z);
          check("neg", neg, e.n);
        end
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        held = '{s: sum, c: cout, v: ovf, z: zero, n: neg};
        check("stall_in_ready", in_ready, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", {sum, cout, ovf, zero, neg}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First transaction also checks the two-cycle latency.
    send(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 1);
    @(negedge clk);
    check("latency_not_early", out_valid, 0);
    @(negedge clk);
    check("latency_two_cycles", out_valid, 1);
    drain();

    send(OP_SADD, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 1, 0, 0, 1);
    send(OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1, 0, 1, 0, 1);
    send(OP_SSUB, 16'h8000, 16'h0001, 16'h8000, 1, 1, 0, 1, 1);
    send(OP_SUB,  16'h0003, 16'h0004, 16'hFFFF, 0, 0, 0, 1, 1);
    send(OP_ADD,  16'h1234, 16'h4321, 16'h5555, 0, 0, 0, 0, 1);
    send(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0, 1);
    send(OP_ADD,  16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 0, 1);
    send(OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1, 1, 1, 0, 1);
    send(OP_SADD, 16'h8000, 16'h8000, 16'h8000, 1, 1, 0, 1, 1);
    send(OP_SSUB, 16'h7FFF, 16'hFFFF, 16'h7FFF, 0, 1, 0, 0, 1);
    send(OP_SSUB, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0, 1, 1);
    drain();

    // Back-to-back stream with a three-cycle consumer stall in the middle.
    fork
      begin
        send(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 1);
        send(OP_ADD, 16'h0010, 16'h0020, 16'h0030, 0, 0, 0, 0, 1);
        send(OP_ADD, 16'h0100, 16'h0200, 16'h0300, 0, 0, 0, 0, 1);
        send(OP_ADD, 16'h1000, 16'h2000, 16'h3000, 0, 0, 0, 0, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight: both must vanish.
    send(OP_ADD, 16'hA000, 16'h0001, 16'h0000, 0, 0, 0, 0, 0);
    send(OP_ADD, 16'h0F0F, 16'h0101, 16'h0000, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_outputs", {sum, cout, ovf, zero, neg}, 0);
    check("async_reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_output_after_reset", out_valid, 0);
    end
    send(OP_ADD, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 0, 1);
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
